// File: rtl/sin_nco_pkg.sv
// sin_nco_pkg
//   Shared definitions for the sine NCO:
//   - quadrant_t      : phase quadrant decoded from the top two phase bits
//   - *_DEF           : default parameter values for sin_nco
//   - lut_entry()     : elaboration-time quarter-wave table generator
package sin_nco_pkg;

   typedef enum logic [1:0] {
      Q0 = 2'd0,
      Q1 = 2'd1,
      Q2 = 2'd2,
      Q3 = 2'd3
   } quadrant_t;

   localparam int OUT_W_DEF      = 16;
   localparam int PHASE_W_DEF    = 32;
   localparam int LUT_ADDR_W_DEF = 8;
   localparam int DIV_DEF        = 1776;

   // round((2^(out_w-1)-1) * sin(pi/2 * (k+0.5) / 2^addr_w)).
   // The sine is a Taylor series (x <= pi/2, error far below one LSB) so the
   // table only needs real add/multiply during constant evaluation.
   function automatic int lut_entry(input int k, input int out_w, input int addr_w);
      real x;
      real x2;
      real term;
      real sum;
      real full;
      x    = 1.5707963267948966 * ($itor(k) + 0.5) / $itor(1 << addr_w);
      x2   = x * x;
      term = x;
      sum  = x;
      for (int n = 1; n < 10; n++) begin
         term = -term * x2 / $itor((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      full = $itor((1 << (out_w - 1)) - 1);
      return $rtoi(full * sum + 0.5);
   endfunction

endpackage

// File: rtl/sin_nco_lut.sv
// sin_quarter_lut
//   Quarter-wave sine magnitude ROM with a registered read. Contents are
//   computed at elaboration from sin_nco_pkg::lut_entry(); every entry is
//   strictly positive, so only OUT_W-1 magnitude bits are stored.
//   Ports:
//     i_clk   : clock
//     i_addr  : table index (already mirrored by the caller for q1/q3)
//     o_data  : unsigned magnitude, valid one cycle after i_addr
module sin_quarter_lut
   import sin_nco_pkg::*;
#(
   parameter int OUT_W      = OUT_W_DEF,
   parameter int LUT_ADDR_W = LUT_ADDR_W_DEF
) (
   input  logic                  i_clk,
   input  logic [LUT_ADDR_W-1:0] i_addr,
   output logic [OUT_W-2:0]      o_data
);

   localparam int N = 1 << LUT_ADDR_W;

   logic [OUT_W-2:0] w_table [N];
   logic [OUT_W-2:0] r_data;

   for (genvar k = 0; k < N; k++) begin : g_tab
      localparam int V = lut_entry(k, OUT_W, LUT_ADDR_W);
      assign w_table[k] = (OUT_W-1)'(V);
   end

   always_ff @(posedge i_clk) begin
      r_data <= w_table[i_addr];
   end

   assign o_data = r_data;

endmodule

// File: rtl/sin_nco.sv
// sin_nco
//   Numerically controlled sine oscillator. A divider produces one tick every
//   DIV enabled cycles; each tick latches the lookup phase (acc + phase_off)
//   and advances acc by ftw. Three pipeline stages follow the tick: phase
//   latch, quarter-wave table read, sign/mirror (and optional gain).
//   Optional feature: define SIN_NCO_AMPLITUDE_EN to add port amp and scale
//   the output by min(amp, 2^(OUT_W-1)) / 2^(OUT_W-1).
//   Ports:
//     CLK          : clock, all logic on posedge
//     RST          : synchronous active-high reset
//     en           : run enable; freezes divider and accumulator when low
//     ftw          : frequency tuning word, sampled on tick
//     phase_off    : lookup phase offset, sampled on tick
//     amp          : gain, unity = 2^(OUT_W-1) (SIN_NCO_AMPLITUDE_EN only)
//     sample_valid : one-cycle strobe with each new sinOut
//     sinOut       : signed sample, held between strobes
module sin_nco
   import sin_nco_pkg::*;
#(
   parameter int OUT_W      = OUT_W_DEF,
   parameter int PHASE_W    = PHASE_W_DEF,
   parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
   parameter int DIV        = DIV_DEF
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    en,
   input  logic [PHASE_W-1:0]      ftw,
   input  logic [PHASE_W-1:0]      phase_off,
`ifdef SIN_NCO_AMPLITUDE_EN
   input  logic [OUT_W-1:0]        amp,
`endif
   output logic                    sample_valid,
   output logic signed [OUT_W-1:0] sinOut
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0]        r_cnt;
   logic [PHASE_W-1:0]      r_acc;
   logic [LUT_ADDR_W+1:0]   r_phase_top;   // quadrant + index; low phase bits dropped
   logic                    r_v1;
   logic                    r_v2;
   quadrant_t               r_q2;          // quadrant aligned with table output

   logic                    w_tick;
   quadrant_t               w_q1;
   logic [LUT_ADDR_W-1:0]   w_idx;
   logic [LUT_ADDR_W-1:0]   w_addr;
   logic [OUT_W-2:0]        w_lut_data;
   logic signed [OUT_W-1:0] w_mag;
   logic signed [OUT_W-1:0] w_signed;
   logic signed [OUT_W-1:0] w_out;

   assign w_tick = en && (r_cnt == CNT_LAST);
   assign w_q1   = quadrant_t'(r_phase_top[LUT_ADDR_W+1 -: 2]);
   assign w_idx  = r_phase_top[LUT_ADDR_W-1:0];
   // q1/q3 run the quarter wave backwards: ~i == N-1-i
   assign w_addr = (w_q1 == Q1 || w_q1 == Q3) ? ~w_idx : w_idx;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt       <= '0;
         r_acc       <= '0;
         r_phase_top <= '0;
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_q2        <= Q0;
      end else begin
         r_v1 <= w_tick;
         r_v2 <= r_v1;
         r_q2 <= w_q1;
         if (en) begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
         end
         if (w_tick) begin
            r_phase_top <= (LUT_ADDR_W+2)'((r_acc + phase_off) >> (PHASE_W - LUT_ADDR_W - 2));
            r_acc       <= r_acc + ftw;
         end
      end
   end

   sin_quarter_lut #(
      .OUT_W      (OUT_W),
      .LUT_ADDR_W (LUT_ADDR_W)
   ) u_lut (
      .i_clk  (CLK),
      .i_addr (w_addr),
      .o_data (w_lut_data)
   );

   assign w_mag    = signed'({1'b0, w_lut_data});
   assign w_signed = (r_q2 == Q2 || r_q2 == Q3) ? -w_mag : w_mag;

`ifdef SIN_NCO_AMPLITUDE_EN
   localparam logic [OUT_W:0] UNITY = {2'b01, {(OUT_W-1){1'b0}}};

   logic [OUT_W:0]            w_gain;
   logic signed [2*OUT_W:0]   w_prod;

   // Gain is clamped to unity so |result| <= |table value| and fits OUT_W.
   assign w_gain = ({1'b0, amp} > UNITY) ? UNITY : {1'b0, amp};
   assign w_prod = (2*OUT_W+1)'(w_signed) * (2*OUT_W+1)'(signed'(w_gain));
   assign w_out  = OUT_W'(w_prod >>> (OUT_W - 1));
`else
   assign w_out  = w_signed;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         sample_valid <= 1'b0;
         sinOut       <= '0;
      end else begin
         sample_valid <= r_v2;
         if (r_v2) begin
            sinOut <= w_out;
         end
      end
   end

endmodule

// File: tb/tb_sin_nco.sv
module tb_sin_nco;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        en = 1'b0;
   logic        en_f = 1'b0;
   logic [31:0] ftw = '0;
   logic [31:0] phase_off = '0;
`ifdef SIN_NCO_AMPLITUDE_EN
   logic [15:0] amp = 16'h8000;
`endif
   logic               sample_valid;
   logic               sv_f;
   logic signed [15:0] sinOut;
   logic signed [15:0] out_f;

   int n_cmp = 0;
   int n_err = 0;

   sin_nco #(.DIV(4)) u_dut (
      .CLK          (CLK),
      .RST          (RST),
      .en           (en),
      .ftw          (ftw),
      .phase_off    (phase_off),
`ifdef SIN_NCO_AMPLITUDE_EN
      .amp          (amp),
`endif
      .sample_valid (sample_valid),
      .sinOut       (sinOut)
   );

   sin_nco #(.DIV(1)) u_fast (
      .CLK          (CLK),
      .RST          (RST),
      .en           (en_f),
      .ftw          (ftw),
      .phase_off    (phase_off),
`ifdef SIN_NCO_AMPLITUDE_EN
      .amp          (amp),
`endif
      .sample_valid (sv_f),
      .sinOut       (out_f)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // Full-circle reference for phase step m of 1024 (ftw = 2^22).
   function automatic int ref_sample(input int m);
      real v;
      v = 32767.0 * $sin(2.0 * 3.141592653589793 * ($itor(m) + 0.5) / 1024.0);
      return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
   endfunction

   // Reset edge falls between the two negedges; returns before the first
   // post-reset edge.
   task automatic do_reset();
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK); RST = 1'b0;
   endtask

   // Counts posedges until the main DUT strobes; n = edges waited.
   task automatic next_strobe(input int budget, output int n,
                              output logic signed [15:0] v, output bit to);
      n  = 0;
      to = 1'b1;
      v  = 'x;
      while (n < budget && to) begin
         @(posedge CLK); #1;
         n++;
         if (sample_valid === 1'b1) begin
            v  = sinOut;
            to = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      en = 1'b1; en_f = 1'b1; ftw = 32'h0040_0000; phase_off = '0;
      do_reset();
      n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
      n_cmp++; if (sinOut !== 16'sd0) begin n_err++; $display("FAIL reset_sinout: got %0d want 0", sinOut); end
      n_cmp++; if (sv_f !== 1'b0) begin n_err++; $display("FAIL reset_fast_valid: got %b want 0", sv_f); end
   endtask

   // Strobe 1 appears after the 6th post-release edge (the 7th cycle).
   task automatic test_first_samples();
      int n; logic signed [15:0] v; bit to;
      en = 1'b1; ftw = 32'h0040_0000; phase_off = '0;
      do_reset();
      next_strobe(20, n, v, to);
      n_cmp++; if (n !== 6) begin n_err++; $display("FAIL first_latency: got %0d want 6", n); end
      n_cmp++; if (v !== 16'sd101) begin n_err++; $display("FAIL first_value: got %0d want 101", v); end
      next_strobe(20, n, v, to);
      n_cmp++; if (n !== 4) begin n_err++; $display("FAIL second_gap: got %0d want 4", n); end
      n_cmp++; if (v !== 16'sd302) begin n_err++; $display("FAIL second_value: got %0d want 302", v); end
   endtask

   // Two enabled edges, five frozen edges, then resume: tick is late by 5.
   task automatic test_enable_freeze();
      int n; int seen; logic signed [15:0] v; bit to;
      en = 1'b1; ftw = 32'h0040_0000; phase_off = '0;
      do_reset();
      @(negedge CLK);
      @(negedge CLK); en = 1'b0;
      seen = 0;
      for (int j = 0; j < 5; j++) begin
         @(negedge CLK);
         if (sample_valid !== 1'b0) seen++;
      end
      en = 1'b1;
      n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL freeze_no_strobe: got %0d strobes want 0", seen); end
      next_strobe(20, n, v, to);
      n_cmp++; if (n !== 4) begin n_err++; $display("FAIL freeze_resume_latency: got %0d want 4", n); end
      n_cmp++; if (v !== 16'sd101) begin n_err++; $display("FAIL freeze_resume_value: got %0d want 101", v); end
   endtask

   task automatic test_full_period();
      logic signed [15:0] s [0:1024];
      int n; logic signed [15:0] v; bit to;
      int bad_gap, total, mx, mn, bad_val, bad_sym;
      en = 1'b1; ftw = 32'h0040_0000; phase_off = '0;
      do_reset();
      bad_gap = 0; total = 0; mx = -100000; mn = 100000; bad_val = 0; bad_sym = 0;
      for (int k = 0; k <= 1024; k++) begin
         next_strobe(20, n, v, to);
         s[k] = v;
         if (k > 0) begin
            total += n;
            if (n != 4) bad_gap++;
         end
      end
      for (int k = 0; k < 1024; k++) begin
         if (int'(s[k]) > mx) mx = int'(s[k]);
         if (int'(s[k]) < mn) mn = int'(s[k]);
         n_cmp++;
         if (s[k] !== 16'(ref_sample(k))) begin
            n_err++; bad_val++;
            if (bad_val < 5) $display("FAIL period_sample[%0d]: got %0d want %0d", k, s[k], ref_sample(k));
         end
      end
      for (int k = 0; k < 512; k++) begin
         n_cmp++;
         if (s[k+512] !== -s[k]) begin
            n_err++; bad_sym++;
            if (bad_sym < 5) $display("FAIL period_antisym[%0d]: got %0d want %0d", k, s[k+512], -s[k]);
         end
      end
      n_cmp++; if (bad_gap !== 0) begin n_err++; $display("FAIL period_gaps: got %0d gaps not 4, want 0", bad_gap); end
      n_cmp++; if (total !== 4096) begin n_err++; $display("FAIL period_cycles: got %0d want 4096", total); end
      n_cmp++; if (s[1024] !== s[0]) begin n_err++; $display("FAIL period_repeat: got %0d want %0d", s[1024], s[0]); end
      n_cmp++; if (mx !== 32767) begin n_err++; $display("FAIL period_max: got %0d want 32767", mx); end
      n_cmp++; if (mn !== -32767) begin n_err++; $display("FAIL period_min: got %0d want -32767", mn); end
   endtask

   // ftw=0: output is set purely by phase_off; a one-cycle phase_off change
   // away from the tick edge must not be seen, a held change must.
   task automatic test_static_phase();
      int n; logic signed [15:0] v; bit to;
      en = 1'b1; ftw = '0; phase_off = 32'h4000_0000;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         next_strobe(20, n, v, to);
         n_cmp++; if (v !== 16'sd32767) begin n_err++; $display("FAIL static_pos[%0d]: got %0d want 32767", k, v); end
      end
      @(negedge CLK); phase_off = 32'hC000_0000;
      @(negedge CLK); phase_off = 32'h4000_0000;
      next_strobe(20, n, v, to);
      n_cmp++; if (v !== 16'sd32767) begin n_err++; $display("FAIL static_glitch_ignored: got %0d want 32767", v); end
      @(negedge CLK); phase_off = 32'hC000_0000;
      for (int k = 0; k < 3; k++) begin
         next_strobe(20, n, v, to);
         n_cmp++; if (v !== -16'sd32767) begin n_err++; $display("FAIL static_neg[%0d]: got %0d want -32767", k, v); end
      end
   endtask

   task automatic test_negative_step();
      int n; logic signed [15:0] v; bit to; int bad_val, bad_gap;
      en = 1'b1; ftw = 32'hFFC0_0000; phase_off = '0;
      do_reset();
      bad_val = 0; bad_gap = 0;
      for (int k = 0; k < 1030; k++) begin
         next_strobe(20, n, v, to);
         if (k > 0 && n != 4) bad_gap++;
         if (k == 1) begin
            n_cmp++; if (v !== -16'sd101) begin n_err++; $display("FAIL negstep_second: got %0d want -101", v); end
         end
         n_cmp++;
         if (v !== 16'(ref_sample((1024 - (k % 1024)) % 1024))) begin
            n_err++; bad_val++;
            if (bad_val < 5) $display("FAIL negstep_sample[%0d]: got %0d want %0d", k, v, ref_sample((1024 - (k % 1024)) % 1024));
         end
      end
      n_cmp++; if (bad_gap !== 0) begin n_err++; $display("FAIL negstep_gaps: got %0d gaps not 4, want 0", bad_gap); end
   endtask

   // Fast instance (DIV=1) has three samples in flight when RST lands.
   task automatic test_reset_in_flight();
      int n; logic signed [15:0] v; bit to; int main_early, fast_early;
      en = 1'b1; en_f = 1'b1; ftw = 32'h0040_0000; phase_off = '0;
      do_reset();
      next_strobe(20, n, v, to);
      next_strobe(20, n, v, to);
      @(negedge CLK);
      @(negedge CLK);
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK); RST = 1'b0;
      n_cmp++; if (sinOut !== 16'sd0) begin n_err++; $display("FAIL flight_sinout_cleared: got %0d want 0", sinOut); end
      n_cmp++; if (out_f !== 16'sd0) begin n_err++; $display("FAIL flight_fast_cleared: got %0d want 0", out_f); end
      main_early = 0; fast_early = 0;
      for (int j = 1; j <= 6; j++) begin
         @(posedge CLK); #1;
         if (j <= 5 && sample_valid !== 1'b0) main_early++;
         if (j <= 2 && sv_f !== 1'b0) fast_early++;
         if (j == 3) begin
            n_cmp++; if (sv_f !== 1'b1 || out_f !== 16'sd101) begin n_err++; $display("FAIL flight_fast_restart: got v=%b %0d want 1 101", sv_f, out_f); end
         end
         if (j == 4) begin
            n_cmp++; if (out_f !== 16'sd302) begin n_err++; $display("FAIL flight_fast_second: got %0d want 302", out_f); end
         end
         if (j == 5) begin
            n_cmp++; if (sinOut !== 16'sd0) begin n_err++; $display("FAIL flight_hold_zero: got %0d want 0", sinOut); end
         end
         if (j == 6) begin
            n_cmp++; if (sample_valid !== 1'b1 || sinOut !== 16'sd101) begin n_err++; $display("FAIL flight_replay_first: got v=%b %0d want 1 101", sample_valid, sinOut); end
         end
      end
      n_cmp++; if (main_early !== 0) begin n_err++; $display("FAIL flight_main_stale: got %0d strobes want 0", main_early); end
      n_cmp++; if (fast_early !== 0) begin n_err++; $display("FAIL flight_fast_stale: got %0d strobes want 0", fast_early); end
      next_strobe(20, n, v, to);
      n_cmp++; if (n !== 4 || v !== 16'sd302) begin n_err++; $display("FAIL flight_replay_second: got gap %0d val %0d want 4 302", n, v); end
   endtask

   // en_f drops after edge 3: two in-flight samples still strobe (edges 4,5),
   // output then holds 503; re-enable after edge 10 gives lut[3]=704 at edge 13.
   task automatic test_enable_drain();
      logic exp_sv; int exp_v; int hold_bad;
      en_f = 1'b1; ftw = 32'h0040_0000; phase_off = '0;
      do_reset();
      hold_bad = 0;
      for (int j = 1; j <= 13; j++) begin
         @(posedge CLK); #1;
         exp_sv = (j >= 3 && j <= 5) || (j == 13);
         exp_v  = (j == 3) ? 101 : (j == 4) ? 302 : (j == 5) ? 503 : 704;
         n_cmp++; if (sv_f !== exp_sv) begin n_err++; $display("FAIL drain_valid[%0d]: got %b want %b", j, sv_f, exp_sv); end
         if (exp_sv) begin
            n_cmp++; if (out_f !== 16'(exp_v)) begin n_err++; $display("FAIL drain_value[%0d]: got %0d want %0d", j, out_f, exp_v); end
         end
         if (j >= 6 && j <= 12 && out_f !== 16'sd503) hold_bad++;
         if (j == 3) begin @(negedge CLK); en_f = 1'b0; end
         if (j == 10) begin @(negedge CLK); en_f = 1'b1; end
      end
      n_cmp++; if (hold_bad !== 0) begin n_err++; $display("FAIL drain_hold: got %0d changed cycles want 0", hold_bad); end
   endtask

`ifdef SIN_NCO_AMPLITUDE_EN
   task automatic test_amplitude();
      int n; logic signed [15:0] v; bit to;
      en = 1'b1; ftw = '0; phase_off = 32'h4000_0000; amp = 16'h4000;
      do_reset();
      next_strobe(20, n, v, to);
      n_cmp++; if (v !== 16'sd16383) begin n_err++; $display("FAIL amp_half: got %0d want 16383", v); end
      amp = 16'hFFFF;
      do_reset();
      next_strobe(20, n, v, to);
      n_cmp++; if (v !== 16'sd32767) begin n_err++; $display("FAIL amp_clamp: got %0d want 32767", v); end
      phase_off = 32'hC000_0000; amp = 16'h4000;
      do_reset();
      next_strobe(20, n, v, to);
      n_cmp++; if (v !== -16'sd16384) begin n_err++; $display("FAIL amp_half_neg: got %0d want -16384", v); end
      amp = 16'h8000;
   endtask
`endif

   initial begin
      test_reset();
      test_first_samples();
      test_enable_freeze();
      test_full_period();
      test_static_phase();
      test_negative_step();
      test_reset_in_flight();
      test_enable_drain();
`ifdef SIN_NCO_AMPLITUDE_EN
      test_amplitude();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sin_nco.md
SIN_NCO -- requirements
Module: sin_nco

Interface
REQ-001 SHALL have parameter OUT_W, default 16, signed output sample width.
REQ-002 SHALL have parameter PHASE_W, default 32, phase accumulator width.
REQ-003 SHALL have parameter LUT_ADDR_W, default 8, quarter-wave table of N=2^LUT_ADDR_W entries.
REQ-004 SHALL have parameter DIV, default 1776, CLK cycles per sample tick (DIV>=1).
REQ-005 SHALL have port CLK  input  1  sole clock; all logic on posedge CLK.
REQ-006 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  run enable; 0 freezes tick counter and phase.
REQ-008 SHALL have port ftw  input  PHASE_W  unsigned frequency tuning word.
REQ-009 SHALL have port phase_off  input  PHASE_W  unsigned phase offset added at table lookup only.
REQ-010 SHALL have port amp  input  OUT_W  unsigned gain, unity = 2^(OUT_W-1); present only with SIN_NCO_AMPLITUDE_EN.
REQ-011 SHALL have port sample_valid  output  1  one-cycle strobe marking a new sinOut value.
REQ-012 SHALL have port sinOut  output  OUT_W  signed sine sample, two's complement.

Function
REQ-013 SHALL count 0..DIV-1 while en=1 and assert internal tick in the cycle the count equals DIV-1, then wrap to 0; DIV=1 ticks every enabled cycle.
REQ-014 SHALL, on tick, latch lookup phase p = (acc + phase_off) mod 2^PHASE_W, then update acc <= (acc + ftw) mod 2^PHASE_W (silent wrap, no flag).
REQ-015 SHALL decode quadrant q = p[PHASE_W-1:PHASE_W-2] and index i = next LUT_ADDR_W bits; lower bits discarded.
REQ-016 SHALL hold table lut[k] = round((2^(OUT_W-1)-1)*sin(pi/2*(k+0.5)/N)), k=0..N-1, all positive.
REQ-017 SHALL output q0: +lut[i]; q1: +lut[N-1-i]; q2: -lut[i]; q3: -lut[N-1-i]; range is +/-(2^(OUT_W-1)-1), never -2^(OUT_W-1).
REQ-018 SHALL use a 3-stage pipeline (phase latch, table read, sign/mirror/gain); sample_valid rises exactly 3 cycles after tick, and sinOut updates in that same cycle.
REQ-019 SHALL hold sinOut between strobes; sample_valid SHALL be high for exactly one cycle per tick.
REQ-020 SHALL, when en falls, let in-flight samples drain and emit their strobes, then hold sinOut and the counter.
REQ-021 SHALL use ftw/phase_off only as sampled on the tick cycle; changes between ticks SHALL have no effect until the next tick.

Reset
REQ-022 SHALL, with RST=1 at a clock edge, clear acc, tick counter and pipeline valids, and set sinOut=0 and sample_valid=0 the following cycle, regardless of en or in-flight samples.
REQ-023 SHALL take RST precedence over en and tick when asserted in the same cycle; the first post-reset tick occurs DIV enabled cycles after RST deasserts.

Configuration
REQ-024 SHALL, with SIN_NCO_AMPLITUDE_EN defined, compute stage 3 as (s*min(amp,2^(OUT_W-1))) >>> (OUT_W-1), arithmetic shift, full-width product, still 3-cycle latency.
REQ-025 SHALL, without SIN_NCO_AMPLITUDE_EN, omit port amp and the multiplier, and output the mirrored table value directly.

Structure
REQ-026 SHALL place quadrant enum (Q0..Q3), default parameter constants and the table-generation function in package sin_nco_pkg.
REQ-027 SHALL implement the table as sub-module sin_quarter_lut (registered read, params OUT_W and LUT_ADDR_W, elaboration-time contents).

Verification
REQ-028 SHALL verify defaults, DIV=4, ftw=2^22, phase_off=0 after reset -> first strobe at cycle 7 after RST release, sinOut=101, second strobe 4 cycles later with 302.
REQ-029 SHALL verify same setup over 1024 strobes -> max +32767, min -32767, sample k+512 == -(sample k), period exactly 4096 cycles.
REQ-030 SHALL verify ftw=0, phase_off=2^30 -> every strobe sinOut=32767; phase_off=2^31+2^30 -> -32767.
REQ-031 SHALL verify ftw=2^32-2^22 (negative step) -> sequence equals the 2^22 run time-reversed; accumulator wrap produces no glitch.
REQ-032 SHALL verify RST pulse mid-run with two samples in flight -> no further strobes, sinOut=0 next cycle; restart replays the REQ-028 sequence.
REQ-033 SHALL verify, with SIN_NCO_AMPLITUDE_EN, amp=2^14 at ftw=0 and phase_off=2^30 -> sinOut=16383; amp=0xFFFF -> clamped to 32767.
